// File: rtl/mc_main_fsm.sv
`default_nettype none
// ============================================================================
// Module   : mc_main_fsm
// Brief    : Moore control FSM for the multicycle datapath; optional
//            illegal_op pulse enabled by defining MC_ILLEGAL_OP_EN.
// Revision : 1.0
// ============================================================================
module mc_main_fsm #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         op,
  output logic               memtoreg,
  output logic               regdst,
  output logic               iord,
  output logic               alusrca,
  output logic [1:0]         alusrcb,
  output logic [1:0]         pcsrc,
  output logic [1:0]         aluop,
  output logic               irwrite,
  output logic               memwrite,
  output logic               pcwrite,
  output logic               branch,
  output logic               regwrite,
  output logic [STATE_W-1:0] state
`ifdef MC_ILLEGAL_OP_EN
  ,
  output logic               illegal_op
`endif
);

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    RTYPEEX = 4'd6,
    RTYPEWB = 4'd7,
    BEQEX   = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JEX     = 4'd11
  } state_t;

  state_t state_q, state_d;

  always_ff @(posedge clk) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH: state_d = DECODE;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = RTYPEEX;
          OP_BEQ:       state_d = BEQEX;
          OP_ADDI:      state_d = ADDIEX;
          OP_J:         state_d = JEX;
          default:      state_d = FETCH;
        endcase
      end
      // op is still held by the instruction register, so re-decode is safe
      MEMADR: begin
        if (op == OP_LW)      state_d = MEMRD;
        else if (op == OP_SW) state_d = MEMWR;
        else                  state_d = FETCH;
      end
      MEMRD:   state_d = MEMWB;
      RTYPEEX: state_d = RTYPEWB;
      ADDIEX:  state_d = ADDIWB;
      default: state_d = FETCH;
    endcase
  end

  always_comb begin
    memtoreg = 1'b0;
    regdst   = 1'b0;
    iord     = 1'b0;
    alusrca  = 1'b0;
    alusrcb  = 2'b00;
    pcsrc    = 2'b00;
    aluop    = 2'b00;
    irwrite  = 1'b0;
    memwrite = 1'b0;
    pcwrite  = 1'b0;
    branch   = 1'b0;
    regwrite = 1'b0;
    case (state_q)
      FETCH: begin
        alusrcb = 2'b01;
        irwrite = 1'b1;
        pcwrite = 1'b1;
      end
      DECODE: alusrcb = 2'b11;
      MEMADR, ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      MEMRD: iord = 1'b1;
      MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
      end
      MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
      end
      RTYPEEX: begin
        alusrca = 1'b1;
        aluop   = 2'b10;
      end
      RTYPEWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
      end
      BEQEX: begin
        alusrca = 1'b1;
        aluop   = 2'b01;
        pcsrc   = 2'b01;
        branch  = 1'b1;
      end
      ADDIWB: regwrite = 1'b1;
      JEX: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
      end
      default: ;
    endcase
  end

  assign state = STATE_W'(state_q);

`ifdef MC_ILLEGAL_OP_EN
  logic illegal_op_q, illegal_op_d;

  always_comb begin
    illegal_op_d = 1'b0;
    if (state_q == DECODE) begin
      illegal_op_d = !(op inside {OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J});
    end
  end

  always_ff @(posedge clk) begin
    if (reset) illegal_op_q <= 1'b0;
    else       illegal_op_q <= illegal_op_d;
  end

  assign illegal_op = illegal_op_q;
`endif

endmodule
`default_nettype wire
